wb_tlb_commit_stage: RTL and testbench

//  Parametrised writeback/commit stage. Sits after MEM and drives GPR writeback, the debug trace port,

---
 rtl/wb_tlb_commit_stage.sv | 178 +++++++++++++++++
 tb/tb_wb_tlb_commit_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tlb_commit_stage.sv
// Writeback/commit stage: GPR writeback, trace port, exception flush and TLB management commit.
// Every architectural side effect is confined to the single cycle in which the instruction commits.
module wb_tlb_commit_stage #(
  parameter int unsigned TLBNUM    = 16,
  parameter int unsigned IDXW      = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned RAND_MODE = 0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ms_to_ws_valid,
  output logic            ws_allowin,
  input  logic [31:0]     ms_pc,
  input  logic            ms_gr_we,
  input  logic [4:0]      ms_dest,
  input  logic [31:0]     ms_result,
  input  logic            ms_ex,
  input  logic            ms_ertn,
  input  logic [3:0]      ms_tlb_op,
  input  logic            ms_srch_found,
  input  logic [IDXW-1:0] ms_srch_index,
  input  logic [IDXW-1:0] csr_tlbidx_index,
  input  logic            csr_tlbidx_ne,
  input  logic [5:0]      csr_estat_ecode,
  output logic            tlb_r_req,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_valid,
  input  logic            tlb_r_e,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic            csr_idx_we,
  output logic            csr_ne_we,
  output logic            csr_ne_w,
  output logic            csr_tlbrd_we,
  output logic            ws_flush,
  output logic            ws_tlb_busy,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [31:0]     debug_wb_pc,
  output logic [3:0]      debug_wb_rf_wen,
  output logic [4:0]      debug_wb_rf_wnum,
  output logic [31:0]     debug_wb_rf_wdata
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} rd_state_e;

  localparam bit         ZeroLat = (RD_LAT == 0);
  localparam logic [1:0] LatInit = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);
  localparam logic [5:0] TapsFull = (IDXW == 2) ? 6'h03 :
                                    (IDXW == 3) ? 6'h06 :
                                    (IDXW == 4) ? 6'h0c :
                                    (IDXW == 5) ? 6'h14 : 6'h30;
  localparam logic [IDXW-1:0] LfsrTaps  = TapsFull[IDXW-1:0];
  localparam logic [IDXW-1:0] RandReset = (RAND_MODE != 0) ? IDXW'(1) : '0;

  logic            ws_valid;
  logic [31:0]     ws_pc;
  logic            ws_gr_we;
  logic [4:0]      ws_dest;
  logic [31:0]     ws_result;
  logic            ws_ex;
  logic            ws_ertn;
  logic [3:0]      ws_tlb_op;
  logic            ws_srch_found;

  rd_state_e       rd_state_q;
  logic [1:0]      lat_q;
  logic [IDXW-1:0] rand_q;

  logic op_srch, op_rd, op_wr, op_fill;
  logic rd_pending, rd_start, rd_data_ok;
  logic ws_ready_go, commit;

  // The CSR file takes the TLBSRCH index straight from MEM; only the strobe comes from here.
  logic unused_srch_index;
  assign unused_srch_index = ^ms_srch_index;

  // Fixed priority on an illegal multi-hot op: srch > rd > wr > fill.
  assign op_srch = ws_tlb_op[3];
  assign op_rd   = ws_tlb_op[2] & ~ws_tlb_op[3];
  assign op_wr   = ws_tlb_op[1] & ~|ws_tlb_op[3:2];
  assign op_fill = ws_tlb_op[0] & ~|ws_tlb_op[3:1];

  assign rd_pending = ws_valid & op_rd & ~ws_ex & ~ws_ertn;
  assign rd_start   = rd_pending & (rd_state_q != StWait);
  assign rd_data_ok = ZeroLat ? (rd_start & tlb_r_valid)
                              : ((rd_state_q == StWait) & (lat_q == 2'd0) & tlb_r_valid);

  assign ws_ready_go = ~rd_pending | rd_data_ok;
  assign ws_allowin  = ~ws_valid | ws_ready_go;
  assign commit      = ws_valid & ws_ready_go & ~ws_ex & ~ws_ertn;
  assign ws_flush    = ws_valid & (ws_ex | ws_ertn);
  assign ws_tlb_busy = ws_valid & |ws_tlb_op;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
    end else if (ws_flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_to_ws_valid && ws_allowin) begin
      ws_pc         <= ms_pc;
      ws_gr_we      <= ms_gr_we;
      ws_dest       <= ms_dest;
      ws_result     <= ms_result;
      ws_ex         <= ms_ex;
      ws_ertn       <= ms_ertn;
      ws_tlb_op     <= ms_tlb_op;
      ws_srch_found <= ms_srch_found;
    end
  end

  // TLBRD sequencing; the request goes out in the first cycle the read sits in WB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= StIdle;
      lat_q      <= 2'd0;
    end else begin
      unique case (rd_state_q)
        StIdle, StDone: begin
          if (rd_start) begin
            lat_q <= LatInit;
            if (ZeroLat) rd_state_q <= tlb_r_valid ? StDone : StIdle;
            else         rd_state_q <= StWait;
          end else begin
            rd_state_q <= StIdle;
          end
        end
        StWait: begin
          if (rd_data_ok) begin
            rd_state_q <= StDone;
          end else if (lat_q != 2'd0) begin
            lat_q <= lat_q - 2'd1;
          end
        end
        default: rd_state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rand_q <= RandReset;
    end else if (RAND_MODE == 0) begin
      rand_q <= (rand_q == IDXW'(TLBNUM - 1)) ? '0 : rand_q + 1'b1;
    end else begin
      rand_q <= {1'b0, rand_q[IDXW-1:1]} ^ (rand_q[0] ? LfsrTaps : '0);
    end
  end

  assign tlb_r_req   = rd_start;
  assign tlb_r_index = csr_tlbidx_index;

  assign tlb_we      = commit & (op_wr | op_fill);
  assign tlb_w_index = op_wr ? csr_tlbidx_index : rand_q;
  assign tlb_w_e     = (csr_estat_ecode == 6'h3f) | ~csr_tlbidx_ne;

  assign csr_ne_we    = commit & (op_srch | op_rd);
  assign csr_ne_w     = op_srch ? ~ws_srch_found : ~tlb_r_e;
  assign csr_idx_we   = commit & op_srch & ws_srch_found;
  assign csr_tlbrd_we = commit & op_rd & tlb_r_e;

  assign rf_we             = commit & ws_gr_we;
  assign rf_waddr          = ws_dest;
  assign rf_wdata          = ws_result;
  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = ws_dest;
  assign debug_wb_rf_wdata = ws_result;

endmodule

// File: tb/tb_wb_tlb_commit_stage.sv
// Directed bench for wb_tlb_commit_stage: expected commits are queued at issue and popped
// whenever the stage raises a commit strobe.
module tb_wb_tlb_commit_stage;

  localparam int unsigned TLBNUM = 16;
  localparam int unsigned IDXW   = 4;
  localparam int unsigned RD_LAT = 2;

  logic            clk = 1'b0;
  logic            resetn;
  logic            ms_to_ws_valid;
  logic            ws_allowin;
  logic [31:0]     ms_pc;
  logic            ms_gr_we;
  logic [4:0]      ms_dest;
  logic [31:0]     ms_result;
  logic            ms_ex;
  logic            ms_ertn;
  logic [3:0]      ms_tlb_op;
  logic            ms_srch_found;
  logic [IDXW-1:0] ms_srch_index;
  logic [IDXW-1:0] csr_tlbidx_index;
  logic            csr_tlbidx_ne;
  logic [5:0]      csr_estat_ecode;
  logic            tlb_r_req;
  logic [IDXW-1:0] tlb_r_index;
  logic            tlb_r_valid;
  logic            tlb_r_e;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic            tlb_w_e;
  logic            csr_idx_we;
  logic            csr_ne_we;
  logic            csr_ne_w;
  logic            csr_tlbrd_we;
  logic            ws_flush;
  logic            ws_tlb_busy;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic [31:0]     debug_wb_pc;
  logic [3:0]      debug_wb_rf_wen;
  logic [4:0]      debug_wb_rf_wnum;
  logic [31:0]     debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_tlb_commit_stage #(
    .TLBNUM   (TLBNUM),
    .IDXW     (IDXW),
    .RD_LAT   (RD_LAT),
    .RAND_MODE(0)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ws_allowin       (ws_allowin),
    .ms_pc            (ms_pc),
    .ms_gr_we         (ms_gr_we),
    .ms_dest          (ms_dest),
    .ms_result        (ms_result),
    .ms_ex            (ms_ex),
    .ms_ertn          (ms_ertn),
    .ms_tlb_op        (ms_tlb_op),
    .ms_srch_found    (ms_srch_found),
    .ms_srch_index    (ms_srch_index),
    .csr_tlbidx_index (csr_tlbidx_index),
    .csr_tlbidx_ne    (csr_tlbidx_ne),
    .csr_estat_ecode  (csr_estat_ecode),
    .tlb_r_req        (tlb_r_req),
    .tlb_r_index      (tlb_r_index),
    .tlb_r_valid      (tlb_r_valid),
    .tlb_r_e          (tlb_r_e),
    .tlb_we           (tlb_we),
    .tlb_w_index      (tlb_w_index),
    .tlb_w_e          (tlb_w_e),
    .csr_idx_we       (csr_idx_we),
    .csr_ne_we        (csr_ne_we),
    .csr_ne_w         (csr_ne_w),
    .csr_tlbrd_we     (csr_tlbrd_we),
    .ws_flush         (ws_flush),
    .ws_tlb_busy      (ws_tlb_busy),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  // TLB read port model: data valid exactly RD_LAT (=2) cycles after the request.
  logic [1:0] rpipe;
  logic       rd_e_val;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) rpipe <= 2'b00;
    else         rpipe <= {rpipe[0], tlb_r_req};
  end
  assign tlb_r_valid = rpipe[1];
  assign tlb_r_e     = rd_e_val;

  // Fill-index model: free-running mod-TLBNUM counter cleared by reset.
  int cyc;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= (cyc + 1) % TLBNUM;
  end

  int          checks = 0;
  int          errors = 0;
  logic [83:0] exp_q[$];
  logic [83:0] mon_obs;
  logic [83:0] mon_exp;
  logic [31:0] pc_next = 32'h1c00_0000;

  function automatic logic [83:0] pack(input logic rfwe, input logic [4:0] wa,
                                       input logic [31:0] wd, input logic [31:0] pc,
                                       input logic [3:0] wen, input logic twe,
                                       input logic [3:0] widx, input logic twe_e,
                                       input logic newe, input logic new_v,
                                       input logic idxwe, input logic rdwe);
    return {rfwe, rfwe ? wa : 5'd0, rfwe ? wd : 32'd0, pc, wen, twe, twe ? widx : 4'd0,
            twe ? twe_e : 1'b0, newe, newe ? new_v : 1'b0, idxwe, rdwe};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any commit visible there.
  task automatic tick();
    @(negedge clk);
    if (resetn && (rf_we || tlb_we || csr_ne_we || csr_idx_we || csr_tlbrd_we)) begin
      mon_obs = pack(rf_we, rf_waddr, rf_wdata, debug_wb_pc, debug_wb_rf_wen, tlb_we,
                     tlb_w_index, tlb_w_e, csr_ne_we, csr_ne_w, csr_idx_we, csr_tlbrd_we);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_commit: observed %h with no pending commit expected", mon_obs);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        checks++;
        assert (mon_obs === mon_exp) else begin
          errors++;
          $error("FAIL commit: observed %h expected %h", mon_obs, mon_exp);
        end
      end
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      ms_to_ws_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic gr_we, input logic [4:0] dest,
                       input logic [31:0] result, input logic ex, input logic found,
                       input logic [3:0] sidx, input logic track, input logic want_allowin);
    logic s, r, w, f;
    logic [3:0] widx;
    int n;
    tick();
    ms_to_ws_valid = 1'b1;
    ms_pc = pc_next;
    ms_gr_we = gr_we;
    ms_dest = dest;
    ms_result = result;
    ms_ex = ex;
    ms_ertn = 1'b0;
    ms_tlb_op = op;
    ms_srch_found = found;
    ms_srch_index = sidx;
    if (want_allowin) chk("allowin_b2b", 32'(ws_allowin), 32'd1);
    n = 0;
    while (!ws_allowin && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("allowin_timeout", 32'(ws_allowin), 32'd1);
    s = op[3];
    r = op[2] & ~op[3];
    w = op[1] & ~|op[3:2];
    f = op[0] & ~|op[3:1];
    widx = w ? csr_tlbidx_index : 4'((cyc + 1) % TLBNUM);
    if (track && !ex)
      exp_q.push_back(pack(gr_we, dest, result, pc_next, {4{gr_we}}, w | f, widx,
                           (csr_estat_ecode == 6'h3f) | ~csr_tlbidx_ne, s | r,
                           s ? ~found : ~rd_e_val, s & found, r & rd_e_val));
    pc_next = pc_next + 32'd4;
  endtask

  // TLBRD issue followed by the request/stall checks through the data-valid cycle.
  task automatic tlbrd_seq(input logic e);
    rd_e_val = e;
    issue(4'b0100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    ms_to_ws_valid = 1'b0;
    chk("rd_req", 32'(tlb_r_req), 32'd1);
    chk("rd_index", 32'(tlb_r_index), 32'd5);
    chk("rd_allowin_t0", 32'(ws_allowin), 32'd0);
    tick();
    chk("rd_allowin_t1", 32'(ws_allowin), 32'd0);
    chk("rd_req_pulse", 32'(tlb_r_req), 32'd0);
    tick();
    chk("rd_allowin_t2", 32'(ws_allowin), 32'd1);
    chk("rd_ne_we", 32'(csr_ne_we), 32'd1);
    drain(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_pc = '0; ms_gr_we = 1'b0; ms_dest = '0; ms_result = '0;
    ms_ex = 1'b0; ms_ertn = 1'b0; ms_tlb_op = '0; ms_srch_found = 1'b0; ms_srch_index = '0;
    csr_tlbidx_index = 4'd5; csr_tlbidx_ne = 1'b0; csr_estat_ecode = 6'd0;
    rd_e_val = 1'b0;
    tick();
    tick();
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_tlb_we", 32'(tlb_we), 32'd0);
    chk("rst_flush", 32'(ws_flush), 32'd0);
    chk("rst_busy", 32'(ws_tlb_busy), 32'd0);
    chk("rst_r_req", 32'(tlb_r_req), 32'd0);
    resetn = 1'b1;

    // Back-to-back ALU writebacks.
    for (int i = 1; i <= 4; i++)
      issue(4'b0000, 1'b1, 5'(i), 32'(i * 'h11), 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    drain(2);

    tlbrd_seq(1'b1);
    tlbrd_seq(1'b0);

    issue(4'b1000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    issue(4'b1000, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
    drain(2);

    // TLBFILL on consecutive commits, across the 15 -> 0 wrap.
    csr_estat_ecode = 6'h3f;
    csr_tlbidx_ne = 1'b1;
    for (int i = 0; i < 20; i++)
      issue(4'b0001, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    drain(2);

    csr_estat_ecode = 6'h00;
    csr_tlbidx_index = 4'd11;
    issue(4'b0010, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    drain(2);
    csr_tlbidx_ne = 1'b0;
    issue(4'b0010, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    drain(2);
    csr_tlbidx_index = 4'd5;

    // Excepting TLBWR: flush, no side effects; a same-cycle accept is squashed.
    issue(4'b0010, 1'b1, 5'd7, 32'hdead_beef, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    chk("ex_flush", 32'(ws_flush), 32'd1);
    chk("ex_tlb_we", 32'(tlb_we), 32'd0);
    chk("ex_rf_we", 32'(rf_we), 32'd0);
    chk("ex_busy", 32'(ws_tlb_busy), 32'd1);
    ms_to_ws_valid = 1'b1;
    ms_ex = 1'b0;
    ms_tlb_op = 4'b0000;
    ms_gr_we = 1'b1;
    ms_dest = 5'd8;
    tick();
    ms_to_ws_valid = 1'b0;
    chk("post_flush_valid", 32'(ws_tlb_busy | rf_we), 32'd0);
    chk("post_flush_flush", 32'(ws_flush), 32'd0);
    drain(2);

    // Reset while the read is outstanding.
    rd_e_val = 1'b1;
    issue(4'b0100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    ms_to_ws_valid = 1'b0;
    chk("rst_rd_req", 32'(tlb_r_req), 32'd1);
    tick();
    resetn = 1'b0;
    #1;
    chk("rst_wait_ne_we", 32'(csr_ne_we), 32'd0);
    chk("rst_wait_tlbrd_we", 32'(csr_tlbrd_we), 32'd0);
    chk("rst_wait_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_wait_busy", 32'(ws_tlb_busy), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tlbrd_seq(1'b1);
    drain(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
